// File: rtl/imem_loader_if.sv
// imem_loader_if
//   Byte-stream input and instruction-memory write port of the program loader.
//   master : loader side (consumes the byte stream, drives the memory write port)
//   slave  : environment side (stream source, memory write sink)
//   Signals: in_data[7:0], in_valid, in_ready, we, waddr[addWidth-1:0],
//            wdata[dataWidth-1:0]
interface imem_loader_if #(
  parameter int addWidth  = 6,
  parameter int dataWidth = 32
);
  logic [7:0]           in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic                 we;
  logic [addWidth-1:0]  waddr;
  logic [dataWidth-1:0] wdata;

  modport master (
    input  in_data, in_valid,
    output in_ready, we, waddr, wdata
  );

  modport slave (
    output in_data, in_valid,
    input  in_ready, we, waddr, wdata
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader
//   Run-time program loader: packs a byte stream big-endian into dataWidth-bit
//   words and writes them to instruction memory at ascending addresses from 0.
//   Holds the CPU (cpu_hold_o) until a load completes.
//   Ports:
//     clk, reset      clock, asynchronous active-high reset
//     start_i         one-cycle load request (honoured in IDLE/DONE only)
//     word_count_i    words to load, 0..2**addWidth, sampled with start_i
//     bus             imem_loader_if.master (byte stream + memory write port)
//     busy_o          load in progress
//     done_o          load finished, held until next accepted start or reset
//     cpu_hold_o      inverse of done_o
//     err_o           checksum mismatch (0 when checksum option is absent)
//   Option macro: IMEM_LOADER_CHECKSUM_EN adds a trailing checksum byte (SUM state).
//
//   state   | meaning
//   IDLE    | after reset, waiting for start
//   RECV    | accepting stream bytes into the shift register
//   WRITE   | one-cycle memory write of the packed word
//   SUM     | accepting the checksum byte (checksum build only)
//   DONE    | load complete, CPU released
module imem_loader #(
  parameter int addWidth  = 6,
  parameter int dataWidth = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic [addWidth:0] word_count_i,
  imem_loader_if.master     bus,
  output logic              busy_o,
  output logic              done_o,
  output logic              cpu_hold_o,
  output logic              err_o
);
  localparam int BPW = dataWidth / 8;
  localparam int BCW = $clog2(BPW + 1);
  localparam logic [BCW-1:0]      BYTES_PER_WORD = BCW'(BPW);
  localparam logic [BCW-1:0]      BYTE_ONE       = BCW'(1);
  localparam logic [addWidth:0]   WORD_ONE       = (addWidth + 1)'(1);
  localparam logic [addWidth-1:0] ADDR_ONE       = addWidth'(1);
  localparam logic [addWidth-1:0] ADDR_MAX       = '1;

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RECV  = 3'd1,
    S_WRITE = 3'd2,
    S_SUM   = 3'd3,
    S_DONE  = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RECV  = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd4
  } state_t;
`endif

  state_t               state_q, state_d;
  logic [addWidth:0]    words_left_q, words_left_d;
  logic [addWidth-1:0]  addr_q, addr_d;
  logic [BCW-1:0]       byte_left_q, byte_left_d;
  logic [dataWidth-1:0] shift_q, shift_d;
  logic                 in_ready_q, in_ready_d;
  logic                 we_q, we_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]           sum_q, sum_d;
  logic                 err_q, err_d;
`endif
  logic                 xfer;

  assign xfer = bus.in_valid & in_ready_q;

  always_comb begin
    state_d      = state_q;
    words_left_d = words_left_q;
    addr_d       = addr_q;
    byte_left_d  = byte_left_q;
    shift_d      = shift_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum_d        = sum_q;
    err_d        = err_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          if (word_count_i == '0) begin
            state_d = S_DONE;
          end else begin
            words_left_d = word_count_i;
            addr_d       = '0;
            byte_left_d  = BYTES_PER_WORD;
            shift_d      = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_d        = '0;
            err_d        = 1'b0;
`endif
            state_d      = S_RECV;
          end
        end
      end
      S_RECV: begin
        if (xfer) begin
          // new byte enters at the LSB end, so the first byte ends up on top
          shift_d     = (shift_q << 8) | dataWidth'(bus.in_data);
          byte_left_d = byte_left_q - BYTE_ONE;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d       = sum_q + bus.in_data;
`endif
          if (byte_left_q == BYTE_ONE) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        words_left_d = words_left_q - WORD_ONE;
        byte_left_d  = BYTES_PER_WORD;
        // saturate so a full-depth load never wraps back to address 0
        if (addr_q != ADDR_MAX) addr_d = addr_q + ADDR_ONE;
        if (words_left_q == WORD_ONE) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = S_SUM;
`else
          state_d = S_DONE;
`endif
        end else begin
          state_d = S_RECV;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_SUM: begin
        if (xfer) begin
          err_d   = (sum_q + bus.in_data) != 8'h00;
          state_d = S_DONE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // outputs registered from the next state so none depends on inputs
    we_d   = (state_d == S_WRITE);
    done_d = (state_d == S_DONE);
`ifdef IMEM_LOADER_CHECKSUM_EN
    in_ready_d = (state_d == S_RECV) || (state_d == S_SUM);
    busy_d     = (state_d == S_RECV) || (state_d == S_WRITE) || (state_d == S_SUM);
`else
    in_ready_d = (state_d == S_RECV);
    busy_d     = (state_d == S_RECV) || (state_d == S_WRITE);
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      words_left_q <= '0;
      addr_q       <= '0;
      byte_left_q  <= '0;
      shift_q      <= '0;
      in_ready_q   <= 1'b0;
      we_q         <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q        <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      words_left_q <= words_left_d;
      addr_q       <= addr_d;
      byte_left_q  <= byte_left_d;
      shift_q      <= shift_d;
      in_ready_q   <= in_ready_d;
      we_q         <= we_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q        <= sum_d;
      err_q        <= err_d;
`endif
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.we       = we_q;
  assign bus.waddr    = addr_q;
  assign bus.wdata    = shift_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign cpu_hold_o   = ~done_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign err_o        = err_q;
`else
  assign err_o        = 1'b0;
`endif
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
//   Table of load scenarios applied in a loop; expected memory writes are
//   pushed to a queue as bytes are driven and popped by a write monitor.
module tb_imem_loader;
  localparam int AW  = 6;
  localparam int DW  = 32;
  localparam int BPW = DW / 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [AW:0]   word_count = '0;
  logic          busy, done, cpu_hold, err;

  imem_loader_if #(.addWidth(AW), .dataWidth(DW)) bus ();

  imem_loader #(.addWidth(AW), .dataWidth(DW)) dut (
    .clk          (clk),
    .reset        (reset),
    .start_i      (start),
    .word_count_i (word_count),
    .bus          (bus),
    .busy_o       (busy),
    .done_o       (done),
    .cpu_hold_o   (cpu_hold),
    .err_o        (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int words;
    int gap;        // idle cycles before each byte
    int mode;       // 0: 12 34 .. DD, 1: counting from 0, 2: counting from 1
    int poke;       // byte index at which a start pulse is injected, -1 none
    bit bad_csum;
    int exp_writes;
    int exp_last;
  } vec_t;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  int  n_tests = 0;
  int  n_fail  = 0;
  int  wcnt    = 0;
  logic [AW-1:0] last_waddr = '0;
  wr_t exp_q[$];
  wr_t got;
  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(int words, int gap, int mode, int poke, bit bad, int ew, int el);
    vec_t v;
    v.words = words; v.gap = gap; v.mode = mode; v.poke = poke;
    v.bad_csum = bad; v.exp_writes = ew; v.exp_last = el;
    return v;
  endfunction

  function automatic logic [7:0] byte_of(int mode, int k);
    logic [7:0] b;
    case (mode)
      0: case (k % 8)
           0: b = 8'h12; 1: b = 8'h34; 2: b = 8'h56; 3: b = 8'h78;
           4: b = 8'hAA; 5: b = 8'hBB; 6: b = 8'hCC; default: b = 8'hDD;
         endcase
      1: b = 8'(k);
      default: b = 8'(k + 1);
    endcase
    return b;
  endfunction

  // write monitor: every we cycle must match the next expected write
  always @(negedge clk) begin
    if (!reset && bus.we === 1'b1) begin
      wcnt++;
      last_waddr = bus.waddr;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_we: got write addr %0h data %0h, expected no write", bus.waddr, bus.wdata);
      end else begin
        got = exp_q.pop_front();
        check("waddr", 64'(bus.waddr), 64'(got.a));
        check("wdata", 64'(bus.wdata), 64'(got.d));
      end
    end
  end

  // presents one byte (after gap idle cycles) and returns at the negedge after it transferred
  task automatic drive_byte(input logic [7:0] b, input int gap, input bit poke);
    int n;
    for (int g = 0; g < gap; g++) begin
      bus.in_data  = 8'hEE;
      bus.in_valid = ~bus.in_ready;  // junk offered only while the loader is not ready
      @(negedge clk);
    end
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    if (poke) begin
      start      = 1'b1;
      word_count = '0;
    end
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 64) begin
      @(negedge clk);
      start = 1'b0;
      n++;
    end
    if (n >= 64) begin
      n_tests++;
      n_fail++;
      $display("FAIL ready_timeout: got in_ready=%b after 64 cycles, expected 1", bus.in_ready);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_load(input vec_t v);
    logic [7:0]    b;
    logic [DW-1:0] w;
    logic [7:0]    sum;
    wr_t           e;
    int            k;
    sum  = '0;
    k    = 0;
    wcnt = 0;
    start      = 1'b1;
    word_count = v.words[AW:0];
    @(negedge clk);
    start = 1'b0;
    if (v.words == 0) begin
      check("zero_done", 64'(done), 64'(1));
      check("zero_hold", 64'(cpu_hold), 64'(0));
      check("zero_ready", 64'(bus.in_ready), 64'(0));
      @(negedge clk);
      check("zero_we_cnt", 64'(wcnt), 64'(0));
      return;
    end
    check("start_ready", 64'(bus.in_ready), 64'(1));
    check("start_busy", 64'(busy), 64'(1));
    check("start_done", 64'(done), 64'(0));
    check("start_hold", 64'(cpu_hold), 64'(1));
    for (int wi = 0; wi < v.words; wi++) begin
      w = '0;
      for (int j = 0; j < BPW; j++) begin
        b = byte_of(v.mode, k);
        sum = sum + b;
        w = (w << 8) | DW'(b);
        if (j == BPW - 1) begin
          e.a = AW'(wi);
          e.d = w;
          exp_q.push_back(e);
        end
        drive_byte(b, v.gap, v.poke == k);
        k++;
      end
    end
    // now in the WRITE cycle of the last word
    check("done_low_in_write", 64'(done), 64'(0));
`ifdef IMEM_LOADER_CHECKSUM_EN
    drive_byte(8'h00 - sum + (v.bad_csum ? 8'h01 : 8'h00), 0, 1'b0);
    bus.in_valid = 1'b0;
    check("err", 64'(err), 64'(v.bad_csum));
`else
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("err", 64'(err), 64'(0));
`endif
    check("end_done", 64'(done), 64'(1));
    check("end_hold", 64'(cpu_hold), 64'(0));
    check("end_busy", 64'(busy), 64'(0));
    check("we_count", 64'(wcnt), 64'(v.exp_writes));
    check("last_addr", 64'(last_waddr), 64'(v.exp_last));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, 64'(bus.in_ready), 64'(0));
    check({tag, "_we"}, 64'(bus.we), 64'(0));
    check({tag, "_waddr"}, 64'(bus.waddr), 64'(0));
    check({tag, "_wdata"}, 64'(bus.wdata), 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_done"}, 64'(done), 64'(0));
    check({tag, "_hold"}, 64'(cpu_hold), 64'(1));
    check({tag, "_err"}, 64'(err), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;

    vecs.push_back(mk(0, 0, 0, -1, 1'b0, 0, 0));    // zero-length load from IDLE
    vecs.push_back(mk(2, 0, 0, -1, 1'b0, 2, 1));    // back-to-back stream
    vecs.push_back(mk(2, 3, 0, -1, 1'b0, 2, 1));    // gaps, valid during WRITE
    vecs.push_back(mk(64, 0, 1, -1, 1'b0, 64, 63)); // full depth
    vecs.push_back(mk(2, 0, 0, 2, 1'b0, 2, 1));     // start while busy ignored
    vecs.push_back(mk(3, 1, 1, -1, 1'b0, 3, 2));
`ifdef IMEM_LOADER_CHECKSUM_EN
    vecs.push_back(mk(1, 0, 2, -1, 1'b0, 1, 0));    // 01 02 03 04 + F6
    vecs.push_back(mk(1, 0, 2, -1, 1'b1, 1, 0));    // 01 02 03 04 + F7
`endif

    #2;
    reset = 1'b1;
    #1;
    check_reset_values("rst0");
    repeat (3) @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) run_load(vecs[i]);

    // reset in the middle of word 0: partial word is dropped, no write issued
    start      = 1'b1;
    word_count = 7'd2;
    @(negedge clk);
    start = 1'b0;
    drive_byte(8'h12, 0, 1'b0);
    drive_byte(8'h34, 0, 1'b0);
    bus.in_valid = 1'b0;
    reset = 1'b1;
    #1;
    check_reset_values("rst_mid");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("idle_after_reset_ready", 64'(bus.in_ready), 64'(0));
    check("idle_after_reset_hold", 64'(cpu_hold), 64'(1));
    run_load(vecs[1]);

    check("queue_drained", 64'(exp_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
